// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared state type and default geometry for the register bank
package reg_bank_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 8;

endpackage

// File: rtl/reg_bank_word.sv
// rtl/reg_bank_word.sv - WIDTH-bit load register with asynchronous reset to zero
module reg_word #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
    end else if (load) begin
      out <= in;
    end
  end

endmodule

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - DEPTH x WIDTH register bank with addressed load, combinational read
// and a run-time clear sequencer that zeroes one word per cycle.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic              done_q, done_n;
  logic [WIDTH-1:0]  word_in;
  logic [WIDTH-1:0]  words [DEPTH];
  logic              wr_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          state_n = CLEAR;
          ptr_n   = '0;
        end
      end
      CLEAR: begin
        if (ptr == LAST_PTR) begin
          state_n = IDLE;
          ptr_n   = '0;
          done_n  = 1'b1;
        end else begin
          ptr_n = ptr + ADDR_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        ptr_n   = '0;
      end
    endcase
  end

  assign busy = (state == CLEAR);
  assign done = done_q;

  // A clear request in IDLE takes priority over a load sampled on the same edge.
  assign wr_ok   = load && (state == IDLE) && !clear;
  assign word_in = busy ? '0 : in;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic hit_addr;
    logic hit_ptr;

    assign hit_addr = (address == ADDR_W'(i));
    assign hit_ptr  = (ptr == ADDR_W'(i));

    reg_word #(
      .WIDTH(WIDTH)
    ) u_word (
      .clk  (clk),
      .rst  (rst),
      .load ((wr_ok && hit_addr) || (busy && hit_ptr)),
      .in   (word_in),
      .out  (words[i])
    );
  end

  // Addresses at or beyond DEPTH match no word and read as zero.
  always_comb begin
    out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (address == ADDR_W'(i)) begin
        out = words[i];
      end
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - directed self-checking bench for reg_bank at DEPTH=8 and DEPTH=5
module tb_reg_bank;

  logic        clk;
  logic        rst;

  logic [15:0] in8;
  logic        load8;
  logic [2:0]  addr8;
  logic        clear8;
  logic [15:0] out8;
  logic        busy8;
  logic        done8;

  logic [15:0] in5;
  logic        load5;
  logic [2:0]  addr5;
  logic        clear5;
  logic [15:0] out5;
  logic        busy5;
  logic        done5;

  int total;
  int passed;
  int cycles;
  int guard;
  int done_seen;

  reg_bank #(.WIDTH(16), .DEPTH(8)) u_bank8 (
    .clk     (clk),
    .rst     (rst),
    .in      (in8),
    .load    (load8),
    .address (addr8),
    .clear   (clear8),
    .out     (out8),
    .busy    (busy8),
    .done    (done8)
  );

  reg_bank #(.WIDTH(16), .DEPTH(5)) u_bank5 (
    .clk     (clk),
    .rst     (rst),
    .in      (in5),
    .load    (load5),
    .address (addr5),
    .clear   (clear5),
    .out     (out5),
    .busy    (busy5),
    .done    (done5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b1;
    in8 = '0; load8 = 1'b0; addr8 = '0; clear8 = 1'b0;
    in5 = '0; load5 = 1'b0; addr5 = '0; clear5 = 1'b0;

    // Reset then read every address
    repeat (2) tick();
    rst = 1'b0;
    tick();
    for (int a = 0; a < 8; a++) begin
      addr8 = 3'(a);
      #1;
      check($sformatf("reset_out_a%0d", a), 32'(out8), 32'h0);
    end
    check("reset_busy", 32'(busy8), 32'h0);
    check("reset_done", 32'(done8), 32'h0);

    // Write/readback with read-during-write
    addr8 = 3'd3; in8 = 16'h1234; load8 = 1'b1;
    #1;
    check("rdw_old", 32'(out8), 32'h0);
    tick();
    load8 = 1'b0;
    #1;
    check("wr_new", 32'(out8), 32'h1234);
    addr8 = 3'd4;
    #1;
    check("neighbour", 32'(out8), 32'h0);

    // Fill and clear
    for (int a = 0; a < 8; a++) begin
      addr8 = 3'(a); in8 = 16'hFFFF; load8 = 1'b1;
      tick();
    end
    load8 = 1'b0;
    clear8 = 1'b1;
    tick();
    clear8 = 1'b0;
    addr8 = 3'd7;
    #1;
    cycles = 0;
    guard  = 0;
    while (busy8 && guard < 20) begin
      check($sformatf("a7_during_clear_c%0d", cycles + 1), 32'(out8), 32'hFFFF);
      cycles++;
      guard++;
      tick();
    end
    check("clear8_busy_cycles", 32'(cycles), 32'd8);
    check("clear8_done_pulse", 32'(done8), 32'h1);
    check("a7_after_clear", 32'(out8), 32'h0);
    tick();
    check("clear8_done_once", 32'(done8), 32'h0);

    // Clear and load in the same IDLE cycle; then loads held through busy
    addr8 = 3'd2; in8 = 16'hAAAA; load8 = 1'b1; clear8 = 1'b1;
    tick();
    clear8 = 1'b0;
    check("collide_busy", 32'(busy8), 32'h1);
    addr8 = 3'd0; in8 = 16'h5555;
    guard = 0;
    while (busy8 && guard < 20) begin
      guard++;
      tick();
    end
    load8 = 1'b0;
    #1;
    check("busy_load_dropped", 32'(out8), 32'h0);
    check("collide_done", 32'(done8), 32'h1);
    addr8 = 3'd2;
    #1;
    check("collide_word2", 32'(out8), 32'h0);
    // Earliest accepted load is the done cycle
    addr8 = 3'd1; in8 = 16'h0BEE; load8 = 1'b1;
    tick();
    load8 = 1'b0;
    #1;
    check("load_in_done_cycle", 32'(out8), 32'h0BEE);

    // Reset on the third busy cycle
    addr8 = 3'd6; in8 = 16'h7777; load8 = 1'b1;
    tick();
    load8 = 1'b0;
    clear8 = 1'b1;
    tick();
    clear8 = 1'b0;
    tick();
    tick();
    check("pre_reset_busy", 32'(busy8), 32'h1);
    rst = 1'b1;
    #1;
    check("reset_mid_busy", 32'(busy8), 32'h0);
    for (int a = 0; a < 8; a++) begin
      addr8 = 3'(a);
      #1;
      check($sformatf("reset_mid_a%0d", a), 32'(out8), 32'h0);
    end
    tick();
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (done8) done_seen++;
      tick();
    end
    check("reset_mid_no_done", 32'(done_seen), 32'd0);

    // DEPTH=5: out-of-range address and short clear sequence
    addr5 = 3'd6; in5 = 16'h1234; load5 = 1'b1;
    tick();
    load5 = 1'b0;
    #1;
    check("d5_oob_read", 32'(out5), 32'h0);
    addr5 = 3'd4; in5 = 16'h00FF; load5 = 1'b1;
    tick();
    load5 = 1'b0;
    #1;
    check("d5_top_word", 32'(out5), 32'h00FF);
    clear5 = 1'b1;
    tick();
    clear5 = 1'b0;
    cycles = 0;
    guard  = 0;
    while (busy5 && guard < 20) begin
      cycles++;
      guard++;
      tick();
    end
    check("d5_busy_cycles", 32'(cycles), 32'd5);
    check("d5_done_pulse", 32'(done5), 32'h1);
    check("d5_top_cleared", 32'(out5), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised bank of DEPTH registers, each WIDTH bits, with a single addressed load port and a combinational read. It is the next generation of the single-bit load register and the fixed-width register. It adds a run-time clear sequencer that wipes the whole bank, one word per cycle, without asserting reset. It sits in the memory/register layer, beneath the CPU datapath, and serves as the base for the RAM and register-file blocks.

## Interface
- WIDTH, 16, bits per word (≥1)
- DEPTH, 8, number of words (≥2; need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in  input  WIDTH  write data
- load  input  1  write enable for the word at address
- address  input  ADDR_W  read/write word select
- clear  input  1  request to zero the whole bank
- out  output  WIDTH  current contents of the word at address
- busy  output  1  clear sequence in progress
- done  output  1  one-cycle pulse when a clear sequence completes

## Operation
- Reset state: every word is 0, state is IDLE, ptr is 0, busy is 0, done is 0, out is 0.
- Read: out = mem[address] combinationally. If address ≥ DEPTH, out is 0.
- Write (IDLE only): on a rising edge with load=1 and address < DEPTH, mem[address] ← in. A load with address ≥ DEPTH is ignored.
- Read-during-write: out shows the old value in the load cycle and the new value after the edge.
- FSM states are IDLE and CLEAR.
  - IDLE, clear=1 at the edge: go to CLEAR with ptr ← 0. A load in the same cycle is dropped; clear has priority.
  - CLEAR, each edge: mem[ptr] ← 0 and ptr ← ptr+1. When ptr = DEPTH−1, go to IDLE and assert done for the next cycle.
  - CLEAR: load and clear are both ignored.
- busy = (state == CLEAR), decoded from state (no extra register).
- done is registered. It is high for exactly one cycle, the first IDLE cycle after CLEAR.
- During CLEAR, out keeps following address. A word reads 0 once ptr has passed it and its old value before that.
- Reset mid-sequence: all words go to 0 immediately and the FSM returns to IDLE. done is not pulsed.

## Timing
- Write latency: 1 edge from load to out.
- Clear latency: busy rises 1 edge after clear is sampled and stays high for exactly DEPTH cycles. done is high on the cycle after busy falls.
- Earliest accepted load after a clear: the cycle in which done=1.
- A clear held high continuously re-arms: it is sampled again in the done cycle and starts a new sequence.
- Reset acts asynchronously on assertion. Release of reset is synchronised by the caller.

## Structure
- Shared package reg_bank_pkg holds:
  - the state typedef {IDLE, CLEAR}
  - the default WIDTH and DEPTH constants
- Sub-module reg_word: a WIDTH-bit register with load and asynchronous reset to 0. It is the generalisation of the single-bit register and is instantiated DEPTH times.
  - Its load input is (load & IDLE & address match) | (CLEAR & ptr match).
  - Its in input is muxed to 0 during CLEAR.
- ptr is ADDR_W bits and never exceeds DEPTH−1.

## Test plan
- Reset then read: rst pulse, then sweep address 0..7 → out = 0 on every address; busy = 0, done = 0.
- Write/readback: load 0x1234 at address 3.
  - out reads 0 in the load cycle and 0x1234 on the next cycle.
  - Address 4 still reads 0.
- Clear sequence (DEPTH=8): fill words with 0xFFFF, pulse clear.
  - busy is high for exactly 8 cycles, then done is high for 1 cycle.
  - Address 7 reads 0xFFFF until the 8th edge, then reads 0.
- Collisions: clear and load (addr 2, 0xAAAA) asserted in the same IDLE cycle → word 2 ends at 0. A load during busy → the word stays 0 after done.
- Reset mid-clear: assert rst on the 3rd busy cycle → busy = 0 immediately, all words read 0, and done never pulses.
- Non-power-of-two (DEPTH=5, ADDR_W=3):
  - load at address 6 is ignored and out reads 0 there.
  - A clear sequence keeps busy high for exactly 5 cycles.
